// File: rtl/pe_sequencer.sv
// pe_sequencer: phase sequencer for a single PE.
// Streams the initial operand block into the PE (LOAD), issues one run pulse
// per iteration (COMPUTE), counts forwarded partial-alpha words to find the end
// of each iteration (TRANSMIT), then waits for the PE's final output (OUTPUT).
// Optional watchdog on the TRANSMIT/OUTPUT waits: define PE_SEQ_TIMEOUT_EN.
module pe_sequencer #(
   parameter int DATA_WIDTH = 16,
   parameter int LOAD_WORDS = 16,
   parameter int TX_WORDS   = 4,
   parameter int CNT_WIDTH  = 8,
   parameter int TIMEOUT    = 255
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [CNT_WIDTH-1:0]    cfg_iters,
   input  logic [CNT_WIDTH-1:0]    cfg_comp_len,
   input  logic                    src_valid,
   input  logic [2*DATA_WIDTH-1:0] src_data,
   output logic                    src_ready,
   output logic                    din_pe_v,
   output logic [2*DATA_WIDTH-1:0] din_pe,
   output logic                    pe_run,
   output logic                    alpha_v,
   input  logic                    tx_v,
   input  logic                    pe_out_v,
   output logic                    busy,
   output logic                    done,
   output logic [CNT_WIDTH-1:0]    iter_cnt,
   output logic                    err
);

   localparam int LD_W = $clog2(LOAD_WORDS + 1);
   localparam int TX_W = $clog2(TX_WORDS + 1);

   localparam logic [LD_W-1:0]      LD_FULL  = LD_W'(LOAD_WORDS);
   localparam logic [LD_W-1:0]      LD_LAST  = LD_W'(LOAD_WORDS - 1);
   localparam logic [TX_W-1:0]      TX_LAST  = TX_W'(TX_WORDS - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ZERO = CNT_WIDTH'(0);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_LOAD     = 3'd1,
      ST_COMPUTE  = 3'd2,
      ST_TRANSMIT = 3'd3,
      ST_OUTPUT   = 3'd4
   } state_t;

   state_t                  state_q;
   logic [LD_W-1:0]         ld_cnt_q;
   logic [TX_W-1:0]         tx_cnt_q;
   logic [CNT_WIDTH-1:0]    comp_cnt_q;
   logic [CNT_WIDTH-1:0]    iter_cnt_q;
   logic [CNT_WIDTH-1:0]    iters_q;
   logic [CNT_WIDTH-1:0]    comp_len_q;
   logic                    din_pe_v_q;
   logic [2*DATA_WIDTH-1:0] din_pe_q;
   logic                    pe_run_q;
   logic                    done_q;

   // Decodes derived purely from registered state.
   logic ld_accept;
   logic ld_last;
   logic comp_last;
   logic tx_last;
   logic last_iter;

   assign src_ready = (state_q == ST_LOAD) && (ld_cnt_q < LD_FULL);
   assign ld_accept = src_valid && src_ready;
   assign ld_last   = (ld_cnt_q == LD_LAST);
   assign comp_last = (comp_cnt_q == (comp_len_q - CNT_ONE));
   assign tx_last   = (tx_cnt_q == TX_LAST);
   assign last_iter = (iter_cnt_q == (iters_q - CNT_ONE));

   assign alpha_v  = ((state_q == ST_COMPUTE) || (state_q == ST_TRANSMIT)) && last_iter;
   assign busy     = (state_q != ST_IDLE);
   assign din_pe_v = din_pe_v_q;
   assign din_pe   = din_pe_q;
   assign pe_run   = pe_run_q;
   assign done     = done_q;
   assign iter_cnt = iter_cnt_q;

`ifdef PE_SEQ_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   logic [WD_W-1:0] wd_cnt_q;
   logic            err_q;
   logic            wait_state;
   logic            wait_event;

   assign wait_state = (state_q == ST_TRANSMIT) || (state_q == ST_OUTPUT);
   assign wait_event = ((state_q == ST_TRANSMIT) && tx_v) ||
                       ((state_q == ST_OUTPUT) && pe_out_v);
   assign err        = err_q;
`else
   assign err = 1'b0;
`endif

   // Phase FSM: state, counters, latched configuration and registered PE-side outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         ld_cnt_q   <= '0;
         tx_cnt_q   <= '0;
         comp_cnt_q <= '0;
         iter_cnt_q <= '0;
         iters_q    <= CNT_ONE;
         comp_len_q <= CNT_ONE;
         din_pe_v_q <= 1'b0;
         din_pe_q   <= '0;
         pe_run_q   <= 1'b0;
         done_q     <= 1'b0;
`ifdef PE_SEQ_TIMEOUT_EN
         wd_cnt_q   <= '0;
         err_q      <= 1'b0;
`endif
      end else begin
         // Pulses default low; load data is forwarded one cycle after the handshake.
         pe_run_q   <= 1'b0;
         done_q     <= 1'b0;
         din_pe_v_q <= ld_accept;
         if (ld_accept) begin
            din_pe_q <= src_data;
         end else begin
            din_pe_q <= din_pe_q;
         end
`ifdef PE_SEQ_TIMEOUT_EN
         err_q <= 1'b0;
`endif

         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  // A zero configuration would never terminate; run it as one.
                  iters_q    <= (cfg_iters == CNT_ZERO) ? CNT_ONE : cfg_iters;
                  comp_len_q <= (cfg_comp_len == CNT_ZERO) ? CNT_ONE : cfg_comp_len;
                  ld_cnt_q   <= '0;
                  tx_cnt_q   <= '0;
                  comp_cnt_q <= '0;
                  iter_cnt_q <= '0;
                  state_q    <= ST_LOAD;
               end else begin
                  state_q <= ST_IDLE;
               end
            end

            ST_LOAD: begin
               if (ld_accept) begin
                  ld_cnt_q <= ld_cnt_q + LD_W'(1);
                  if (ld_last) begin
                     comp_cnt_q <= '0;
                     pe_run_q   <= 1'b1;
                     state_q    <= ST_COMPUTE;
                  end else begin
                     state_q <= ST_LOAD;
                  end
               end else begin
                  state_q <= ST_LOAD;
               end
            end

            ST_COMPUTE: begin
               if (comp_last) begin
                  tx_cnt_q <= '0;
                  state_q  <= ST_TRANSMIT;
               end else begin
                  comp_cnt_q <= comp_cnt_q + CNT_ONE;
                  state_q    <= ST_COMPUTE;
               end
            end

            ST_TRANSMIT: begin
               if (tx_v) begin
                  tx_cnt_q <= tx_cnt_q + TX_W'(1);
                  if (tx_last && last_iter) begin
                     state_q <= ST_OUTPUT;
                  end else if (tx_last) begin
                     // Next iteration: fresh run pulse and counters.
                     iter_cnt_q <= iter_cnt_q + CNT_ONE;
                     tx_cnt_q   <= '0;
                     comp_cnt_q <= '0;
                     pe_run_q   <= 1'b1;
                     state_q    <= ST_COMPUTE;
                  end else begin
                     state_q <= ST_TRANSMIT;
                  end
               end else begin
                  state_q <= ST_TRANSMIT;
               end
            end

            ST_OUTPUT: begin
               if (pe_out_v) begin
                  done_q  <= 1'b1;
                  state_q <= ST_IDLE;
               end else begin
                  state_q <= ST_OUTPUT;
               end
            end

            default: begin
               state_q <= ST_IDLE;
            end
         endcase

`ifdef PE_SEQ_TIMEOUT_EN
         // Watchdog: abort a stalled TRANSMIT/OUTPUT wait without signalling done.
         if (!wait_state || wait_event) begin
            wd_cnt_q <= '0;
         end else if (wd_cnt_q == WD_LAST) begin
            wd_cnt_q <= '0;
            err_q    <= 1'b1;
            state_q  <= ST_IDLE;
         end else begin
            wd_cnt_q <= wd_cnt_q + WD_W'(1);
         end
`endif
      end
   end

endmodule

// File: tb/tb_pe_sequencer.sv
// Directed testbench for pe_sequencer (default parameters).
// The watchdog scenario is only exercised when PE_SEQ_TIMEOUT_EN is defined.
module tb_pe_sequencer;

   logic        clk;
   logic        rst;
   logic        start;
   logic [7:0]  cfg_iters;
   logic [7:0]  cfg_comp_len;
   logic        src_valid;
   logic [31:0] src_data;
   logic        src_ready;
   logic        din_pe_v;
   logic [31:0] din_pe;
   logic        pe_run;
   logic        alpha_v;
   logic        tx_v;
   logic        pe_out_v;
   logic        busy;
   logic        done;
   logic [7:0]  iter_cnt;
   logic        err;

   int total = 0;
   int bad   = 0;
   int run_cnt  = 0;
   int done_cnt = 0;

   pe_sequencer dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .cfg_iters    (cfg_iters),
      .cfg_comp_len (cfg_comp_len),
      .src_valid    (src_valid),
      .src_data     (src_data),
      .src_ready    (src_ready),
      .din_pe_v     (din_pe_v),
      .din_pe       (din_pe),
      .pe_run       (pe_run),
      .alpha_v      (alpha_v),
      .tx_v         (tx_v),
      .pe_out_v     (pe_out_v),
      .busy         (busy),
      .done         (done),
      .iter_cnt     (iter_cnt),
      .err          (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count run and done pulses mid-cycle.
   always @(negedge clk) begin
      if (pe_run) run_cnt <= run_cnt + 1;
      if (done)   done_cnt <= done_cnt + 1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      int w;
      rst = 1'b1; start = 1'b0; cfg_iters = 8'd0; cfg_comp_len = 8'd0;
      src_valid = 1'b0; src_data = 32'd0; tx_v = 1'b0; pe_out_v = 1'b0;

      // ---- reset then idle
      repeat (3) step();
      chk1("rst_src_ready", src_ready, 1'b0);
      chk1("rst_din_pe_v", din_pe_v, 1'b0);
      chkw("rst_din_pe", din_pe, 32'd0);
      chk1("rst_pe_run", pe_run, 1'b0);
      chk1("rst_alpha_v", alpha_v, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_done", done, 1'b0);
      chk1("rst_err", err, 1'b0);
      chkw("rst_iter_cnt", 32'(iter_cnt), 32'd0);
      rst = 1'b0; src_valid = 1'b1; src_data = 32'hDEAD_BEEF;
      repeat (3) begin
         step();
         chk1("idle_src_ready", src_ready, 1'b0);
         chk1("idle_busy", busy, 1'b0);
         chk1("idle_din_pe_v", din_pe_v, 1'b0);
      end

      // ---- full run: 3 iterations, 5 compute cycles
      cfg_iters = 8'd3; cfg_comp_len = 8'd5; start = 1'b1;
      step();
      start = 1'b0;
      chk1("load_src_ready", src_ready, 1'b1);
      chk1("load_busy", busy, 1'b1);
      for (int i = 0; i < 16; i++) begin
         src_data = 32'hA5A5_0000 + 32'(i);
         step();
         chk1("load_din_v", din_pe_v, 1'b1);
         chkw("load_din", din_pe, 32'hA5A5_0000 + 32'(i));
         chk1("load_ready_after", src_ready, (i < 15));
      end
      src_valid = 1'b0;
      for (int it = 0; it < 3; it++) begin
         chk1("it_pe_run", pe_run, 1'b1);
         chkw("it_iter_cnt", 32'(iter_cnt), 32'(it));
         chk1("it_alpha", alpha_v, (it == 2));
         // tx_v burst and a stray start during COMPUTE must be ignored
         tx_v = (it == 0); start = (it == 0);
         for (int c = 1; c < 5; c++) begin
            step();
            chk1("comp_pe_run", pe_run, 1'b0);
            chk1("comp_alpha", alpha_v, (it == 2));
         end
         step();
         tx_v = 1'b0; start = 1'b0;
         chk1("tx_alpha", alpha_v, (it == 2));
         chkw("tx_iter_cnt", 32'(iter_cnt), 32'(it));
         step(); step();
         chk1("tx_gap_pe_run", pe_run, 1'b0);
         chk1("tx_gap_busy", busy, 1'b1);
         for (int k = 0; k < 4; k++) begin
            tx_v = 1'b1;
            step();
            tx_v = 1'b0;
            if (k < 3) begin
               chk1("tx_partial_pe_run", pe_run, 1'b0);
               chkw("tx_partial_iter", 32'(iter_cnt), 32'(it));
               step();
            end
         end
      end
      chk1("out_pe_run", pe_run, 1'b0);
      chk1("out_alpha", alpha_v, 1'b0);
      chk1("out_busy", busy, 1'b1);
      chk1("out_done", done, 1'b0);
      chkw("out_iter_cnt", 32'(iter_cnt), 32'd2);
      step(); step();
      chk1("out_wait_done", done, 1'b0);
      chk1("out_wait_busy", busy, 1'b1);
      pe_out_v = 1'b1;
      step();
      pe_out_v = 1'b0;
      chk1("fin_done", done, 1'b1);
      chk1("fin_busy", busy, 1'b0);
      chk1("fin_alpha", alpha_v, 1'b0);
      step();
      chk1("fin_done_low", done, 1'b0);
      chkw("full_run_count", 32'(run_cnt), 32'd3);
      chkw("full_done_count", 32'(done_cnt), 32'd1);

      // ---- load backpressure: 1 iteration, 2 compute cycles
      cfg_iters = 8'd1; cfg_comp_len = 8'd2; start = 1'b1;
      step();
      start = 1'b0;
      w = 0;
      for (int c = 0; c < 31; c++) begin
         src_valid = (c % 2 == 0);
         src_data  = 32'h0BAD_0000 + 32'(w);
         step();
         if (src_valid) begin
            chk1("bp_din_v", din_pe_v, 1'b1);
            chkw("bp_din", din_pe, 32'h0BAD_0000 + 32'(w));
            chk1("bp_pe_run", pe_run, (w == 15));
            w++;
         end else begin
            chk1("bp_din_v_idle", din_pe_v, 1'b0);
            chk1("bp_pe_run_idle", pe_run, 1'b0);
         end
      end
      src_valid = 1'b0;
      chk1("bp_alpha", alpha_v, 1'b1);
      step();
      chk1("bp_comp1_pe_run", pe_run, 1'b0);
      step();
      tx_v = 1'b1;
      repeat (4) step();
      tx_v = 1'b0;
      chk1("bp_out_busy", busy, 1'b1);
      chk1("bp_out_alpha", alpha_v, 1'b0);
      pe_out_v = 1'b1;
      step();
      pe_out_v = 1'b0;
      chk1("bp_done", done, 1'b1);
      step();

      // ---- zero configs behave as 1/1
      cfg_iters = 8'd0; cfg_comp_len = 8'd0; src_valid = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      repeat (16) step();
      src_valid = 1'b0;
      chk1("zero_pe_run", pe_run, 1'b1);
      chk1("zero_alpha", alpha_v, 1'b1);
      step();
      chk1("zero_tx_pe_run", pe_run, 1'b0);
      chk1("zero_tx_alpha", alpha_v, 1'b1);
      tx_v = 1'b1;
      repeat (4) step();
      tx_v = 1'b0;
      chk1("zero_out_alpha", alpha_v, 1'b0);
      chk1("zero_out_busy", busy, 1'b1);
      pe_out_v = 1'b1;
      step();
      pe_out_v = 1'b0;
      chk1("zero_done", done, 1'b1);
      step();
      chkw("zero_run_count", 32'(run_cnt), 32'd5);
      chkw("zero_done_count", 32'(done_cnt), 32'd3);

      // ---- reset in TRANSMIT
      cfg_iters = 8'd2; cfg_comp_len = 8'd1; src_valid = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      repeat (16) step();
      chk1("rt_pe_run", pe_run, 1'b1);
      step();
      tx_v = 1'b1;
      step(); step();
      tx_v = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk1("rt_busy", busy, 1'b0);
      chk1("rt_src_ready", src_ready, 1'b0);
      chk1("rt_alpha", alpha_v, 1'b0);
      chk1("rt_din_v", din_pe_v, 1'b0);
      chkw("rt_din", din_pe, 32'd0);
      chkw("rt_iter_cnt", 32'(iter_cnt), 32'd0);
      tx_v = 1'b1; pe_out_v = 1'b1;
      repeat (6) step();
      tx_v = 1'b0; pe_out_v = 1'b0; src_valid = 1'b0;
      step();
      chk1("rt_after_busy", busy, 1'b0);
      chkw("rt_run_count", 32'(run_cnt), 32'd6);
      chkw("rt_done_count", 32'(done_cnt), 32'd3);
      chk1("rt_err", err, 1'b0);

`ifdef PE_SEQ_TIMEOUT_EN
      // ---- watchdog: no tx_v in TRANSMIT
      cfg_iters = 8'd1; cfg_comp_len = 8'd1; src_valid = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      repeat (16) step();
      src_valid = 1'b0;
      step();
      for (int n = 0; n < 254; n++) begin
         step();
         chk1("wd_wait_err", err, 1'b0);
         chk1("wd_wait_busy", busy, 1'b1);
      end
      step();
      chk1("wd_err", err, 1'b1);
      chk1("wd_busy", busy, 1'b0);
      chk1("wd_done", done, 1'b0);
      step();
      chk1("wd_err_low", err, 1'b0);
      chkw("wd_done_count", 32'(done_cnt), 32'd3);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pe_sequencer.md
# pe_sequencer

Phase sequencer for a single PE. It streams the initial operand block into the PE, issues one run pulse per iteration, and counts forwarded partial-alpha words to detect the end of each iteration. On the last iteration it asserts `alpha_v`, then waits for the PE's final output and reports `done`. It sits between the array-level host/loader and one `pe` instance, and implements the LOAD/COMPUTE/TRANSMIT/OUTPUT phase flow the PE expects.

## Interface
Parameters:
- `DATA_WIDTH`, 16: real/imag component width; a data word is `2*DATA_WIDTH` bits.
- `LOAD_WORDS`, 16: words per load phase (`2*REG_NUM`).
- `TX_WORDS`, 4: `tx_v` pulses that end one iteration.
- `CNT_WIDTH`, 8: width of the config and counter fields.
- `TIMEOUT`, 255: watchdog limit in cycles; used only with the macro described under Configuration.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  start pulse; sampled only in IDLE.
- `cfg_iters`  in  CNT_WIDTH  iteration count; latched on start; 0 is treated as 1.
- `cfg_comp_len`  in  CNT_WIDTH  COMPUTE cycles per iteration; latched on start; 0 is treated as 1.
- `src_valid`  in  1  upstream word valid.
- `src_data`  in  2*DATA_WIDTH  upstream word.
- `src_ready`  out  1  high iff state is LOAD and fewer than LOAD_WORDS words have been accepted.
- `din_pe_v`  out  1  load-data valid to the PE.
- `din_pe`  out  2*DATA_WIDTH  load data to the PE.
- `pe_run`  out  1  one-cycle iteration start pulse to the PE.
- `alpha_v`  out  1  high throughout the last iteration.
- `tx_v`  in  1  PE forwarded a partial-alpha word (`dout_tx_v`).
- `pe_out_v`  in  1  PE final output valid (`dout_pe_v`).
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle completion pulse.
- `iter_cnt`  out  CNT_WIDTH  index of the current iteration.
- `err`  out  1  one-cycle watchdog pulse; constant 0 without the macro.

## Operation
- States: IDLE, LOAD, COMPUTE, TRANSMIT, OUTPUT.
- IDLE:
  - On `start`, latch the configs, clear all counters and go to LOAD.
- LOAD:
  - A word is accepted when `src_valid && src_ready`.
  - Each accepted word increments `ld_cnt`.
  - After word LOAD_WORDS is accepted, go to COMPUTE.
- COMPUTE:
  - `pe_run` is high in the first cycle of the state only.
  - `comp_cnt` counts up from 0; at `comp_cnt == cfg_comp_len-1`, go to TRANSMIT.
- TRANSMIT:
  - Count `tx_v` pulses in `tx_cnt`.
  - On pulse TX_WORDS, if `iter_cnt == cfg_iters-1`, go to OUTPUT.
  - Otherwise increment `iter_cnt`, clear `tx_cnt`, and go to COMPUTE (new `pe_run`).
- OUTPUT:
  - On `pe_out_v`, pulse `done` and go to IDLE.
- `alpha_v` is high iff state is COMPUTE or TRANSMIT and `iter_cnt == cfg_iters-1`.
- Counter widths:
  - `ld_cnt` is `$clog2(LOAD_WORDS+1)` bits.
  - `tx_cnt` is `$clog2(TX_WORDS+1)` bits.
  - No counter wraps; every counter clears on state entry.
- Inputs ignored outside their state:
  - `tx_v` outside TRANSMIT.
  - `pe_out_v` outside OUTPUT.
  - `start` while `busy`.

## Timing
- Reset: state IDLE. `src_ready`, `din_pe_v`, `pe_run`, `alpha_v`, `busy`, `done` and `err` are 0; `din_pe` and `iter_cnt` are 0.
- Reset has priority over every other event, including mid-operation. After reset, no `pe_run` or `done` is issued.
- `start` registered in IDLE: LOAD begins next cycle, with `src_ready`=1 in that cycle.
- `din_pe_v`/`din_pe` are registered: a word accepted in cycle N appears in cycle N+1.
- COMPUTE is entered the cycle after the last load handshake; `pe_run` is high in that cycle.
- Per iteration, COMPUTE lasts exactly `cfg_comp_len` cycles.
- The state changes the cycle after the terminating `tx_v` or `pe_out_v` is sampled.
- `done` is high in the cycle the state returns to IDLE; `busy` is 0 in that same cycle.
- `tx_v` arriving in the last COMPUTE cycle is not counted.

## Configuration
- Macro: `PE_SEQ_TIMEOUT_EN`.
- Defined:
  - A watchdog counts consecutive cycles in TRANSMIT or OUTPUT with no `tx_v`/`pe_out_v`.
  - When it reaches TIMEOUT: pulse `err` for one cycle, go to IDLE, and do not pulse `done`.
  - The watchdog clears on every `tx_v`/`pe_out_v` and on state change.
- Undefined: no watchdog logic is built; `err` is tied to 0, and TRANSMIT/OUTPUT wait indefinitely.

## Test plan
- Reset then idle: after `rst` for 3 cycles, all outputs are 0. With `src_valid`=1 and no `start`, `src_ready` stays 0.
- Full run, `cfg_iters`=3, `cfg_comp_len`=5, `src_valid` always 1:
  - Words 0..15 appear on `din_pe` in cycles 2..17 after `start`.
  - `pe_run` pulses 3 times.
  - `alpha_v` is high only while `iter_cnt`=2.
  - After `pe_out_v`, `done` pulses once.
- Load backpressure: with `src_valid` toggling every other cycle, all 16 words arrive in order. `pe_run` follows 1 cycle after the 16th handshake.
- Zero configs: `cfg_iters`=0, `cfg_comp_len`=0 behave as 1/1. There is one `pe_run`, with `alpha_v` high from it.
- Ignored inputs and reset: a `tx_v` burst during COMPUTE and `start` mid-run have no effect. `rst` in TRANSMIT returns the block to IDLE, with `busy`=0 next cycle.
- With `PE_SEQ_TIMEOUT_EN`: with no `tx_v` for 255 cycles in TRANSMIT, `err` pulses, `done` stays 0, and the state returns to IDLE.
